// File: rtl/cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_pkg
// Purpose  : Shared constants and read-FSM state type for the CAVLC front end.
// Revision : 1.0 - initial release
// ============================================================================
package cavlc_pkg;

  localparam int BLK_SIZE = 16;
  localparam int ZZ_LAST  = 15;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_SCAN = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/zigzagOrderROM.sv
`default_nettype none
// ============================================================================
// Module   : zigzagOrderROM
// Purpose  : 4x4 zigzag scan position -> raster coefficient index lookup.
// Revision : 1.0 - initial release
// ============================================================================
module zigzagOrderROM (
  input  logic [3:0] addr,
  output logic [3:0] data
);

  always_comb begin
    case (addr)
      4'd0:    data = 4'd0;
      4'd1:    data = 4'd1;
      4'd2:    data = 4'd4;
      4'd3:    data = 4'd8;
      4'd4:    data = 4'd5;
      4'd5:    data = 4'd2;
      4'd6:    data = 4'd3;
      4'd7:    data = 4'd6;
      4'd8:    data = 4'd9;
      4'd9:    data = 4'd12;
      4'd10:   data = 4'd13;
      4'd11:   data = 4'd10;
      4'd12:   data = 4'd7;
      4'd13:   data = 4'd11;
      4'd14:   data = 4'd14;
      default: data = 4'd15;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/zz_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : zz_skid_fifo
// Purpose  : Two-entry output FIFO holding {data, idx, last} scan beats.
// Revision : 1.0 - initial release
// ============================================================================
module zz_skid_fifo #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  // Storage is cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= ~r_wptr;
      end
      if (pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/zigzag_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_scan_ctrl
// Purpose  : Ping-pong BRAM load in raster order, zigzag read-out to CAVLC.
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_scan_ctrl
  import cavlc_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int addrWIDTH = 4,
  parameter int BANKS     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 bram_ena,
  output logic                 bram_wea,
  output logic [addrWIDTH:0]   bram_addra,
  output logic [WIDTH-1:0]     bram_dia,
  output logic                 bram_enb,
  output logic [addrWIDTH:0]   bram_addrb,
  input  logic [WIDTH-1:0]     bram_dob,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [addrWIDTH-1:0] out_idx,
  output logic                 out_last
);

  localparam int c_tag_w = WIDTH + addrWIDTH + 1;

  logic [BANKS-1:0]     r_full;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [addrWIDTH-1:0] r_wr_cnt;
  logic [addrWIDTH-1:0] r_rd_cnt;
  logic [addrWIDTH-1:0] r_infl_idx;
  logic                 r_infl;
  rd_state_t            r_state;
  rd_state_t            w_state_nxt;

  logic                 w_wr;
  logic                 w_wr_done;
  logic                 w_issue;
  logic                 w_rd_done;
  logic                 w_pop;
  logic [1:0]           w_fifo_count;
  logic [2:0]           w_occ;
  logic [3:0]           w_zz;
  logic [BANKS-1:0]     w_set;
  logic [BANKS-1:0]     w_clr;
  logic [c_tag_w-1:0]   w_push_tag;
  logic [c_tag_w-1:0]   w_head;

  // Write side: port A follows the accepted coefficient combinationally.
  assign in_ready   = rst & ~r_full[r_wr_bank];
  assign w_wr       = in_valid & in_ready;
  assign w_wr_done  = w_wr & (r_wr_cnt == addrWIDTH'(ZZ_LAST));
  assign bram_ena   = w_wr;
  assign bram_wea   = w_wr;
  assign bram_addra = {r_wr_bank, r_wr_cnt};
  assign bram_dia   = in_data;

  zigzagOrderROM u_rom (
    .addr (r_rd_cnt),
    .data (w_zz)
  );

  // Occupancy counts the beat leaving this cycle so a draining FIFO sustains 1/clk.
  assign w_occ      = {1'b0, w_fifo_count} + {2'b0, r_infl} - {2'b0, w_pop};
  assign w_rd_done  = w_issue & (r_rd_cnt == addrWIDTH'(ZZ_LAST));
  assign bram_enb   = w_issue;
  assign bram_addrb = {r_rd_bank, w_zz};

  // The first read is issued on the cycle a bank is seen full, saving a cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_issue     = (w_occ < 3'd2);
          w_state_nxt = R_SCAN;
        end
      end
      R_SCAN: begin
        w_issue = (w_occ < 3'd2);
        if (w_rd_done) begin
          w_state_nxt = r_full[~r_rd_bank] ? R_SCAN : R_IDLE;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_done) w_set[r_wr_bank] = 1'b1;
    if (w_rd_done) w_clr[r_rd_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_infl     <= 1'b0;
      r_infl_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= (r_full | w_set) & ~w_clr;
      r_infl  <= w_issue;
      if (w_issue) begin
        r_infl_idx <= r_rd_cnt;
        r_rd_cnt   <= r_rd_cnt + addrWIDTH'(1);
        if (w_rd_done) r_rd_bank <= ~r_rd_bank;
      end
      if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + addrWIDTH'(1);
        if (w_wr_done) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  assign w_push_tag = {bram_dob, r_infl_idx, (r_infl_idx == addrWIDTH'(ZZ_LAST))};

  zz_skid_fifo #(
    .DW (c_tag_w)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_infl),
    .push_data (w_push_tag),
    .pop       (w_pop),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign out_valid = (w_fifo_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign {out_data, out_idx, out_last} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_scan_ctrl
// Purpose  : Directed self-checking bench with a behavioural dual-port BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_scan_ctrl;

  localparam int W  = 9;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW:0]   bram_addra;
  logic [W-1:0]  bram_dia;
  logic          bram_enb;
  logic [AW:0]   bram_addrb;
  logic [W-1:0]  bram_dob;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  zigzag_scan_ctrl #(.WIDTH(W), .addrWIDTH(AW), .BANKS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dia   (bram_dia),
    .bram_enb   (bram_enb),
    .bram_addrb (bram_addrb),
    .bram_dob   (bram_dob),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem [32];
  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dia;
    if (bram_enb) bram_dob <= mem[bram_addrb];
  end

  int n_vec = 0;
  int n_err = 0;
  int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = W'(5); out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++;
    if ({bram_ena, bram_wea, bram_enb} !== 3'b000) begin
      n_err++; $display("FAIL reset_bram_en got %b want 000", {bram_ena, bram_wea, bram_enb});
    end
    n_vec++;
    if ({out_valid, out_last, out_idx, out_data} !== '0) begin
      n_err++; $display("FAIL reset_outputs got v=%b l=%b i=%0d d=%0d want all 0", out_valid, out_last, out_idx, out_data);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_single_block();
    int i = 0, k = 0, acc15 = -1, first = -1, prev = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && k < 16; c++) begin
      in_valid = (i < 16); in_data = W'(i);
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = cyc;
        n_vec++;
        if (out_data !== W'(zz[k]) || out_idx !== AW'(k) || out_last !== (k == 15)) begin
          n_err++; $display("FAIL single_beat%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                            k, out_data, out_idx, out_last, zz[k], k, (k == 15));
        end
        if (k > 0) begin
          n_vec++;
          if (cyc != prev + 1) begin n_err++; $display("FAIL single_gap beat%0d got gap %0d want 1", k, cyc - prev); end
        end
        prev = cyc; k++;
      end
      if (in_valid && in_ready) begin
        if (i == 15) acc15 = cyc + 1;
        i++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (k != 16) begin n_err++; $display("FAIL single_count got %0d want 16", k); end
    n_vec++;
    if (first != acc15 + 2) begin n_err++; $display("FAIL single_latency got %0d want 2", first - acc15); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_extra got out_valid=%b want 0", out_valid); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int i = 0, k = 0;
    int pat [4] = '{1, 0, 0, 1};
    logic held = 1'b0;
    logic [W+AW:0] hv = '0;
    for (int c = 0; c < 200 && k < 16; c++) begin
      in_valid = (i < 16); in_data = W'(20 + i); out_ready = (pat[c % 4] != 0);
      @(negedge clk);
      if (held) begin
        n_vec++;
        if (!out_valid || {out_data, out_idx, out_last} !== hv) begin
          n_err++; $display("FAIL bp_hold got v=%b d=%0d i=%0d want held d=%0d i=%0d",
                            out_valid, out_data, out_idx, hv[W+AW:AW+1], hv[AW:1]);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_data !== W'(20 + zz[k]) || out_idx !== AW'(k) || out_last !== (k == 15)) begin
          n_err++; $display("FAIL bp_beat%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                            k, out_data, out_idx, out_last, 20 + zz[k], k, (k == 15));
        end
        k++;
      end
      held = out_valid && !out_ready;
      hv   = {out_data, out_idx, out_last};
      if (in_valid && in_ready) i++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (k != 16) begin n_err++; $display("FAIL bp_count got %0d want 16", k); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_duplicate got out_valid=%b want 0", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    int i = 0, k = 0, rk = 0, prev = 0, exp = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && k < 48; c++) begin
      in_valid = (i < 48); in_data = W'(i);
      @(negedge clk);
      if (in_valid && in_ready) begin
        n_vec++;
        if (!bram_ena || !bram_wea || bram_addra !== 5'(i % 32) || bram_dia !== W'(i)) begin
          n_err++; $display("FAIL b2b_write%0d got en=%b we=%b a=0x%h d=%0d want a=0x%h d=%0d",
                            i, bram_ena, bram_wea, bram_addra, bram_dia, i % 32, i);
        end
        i++;
      end
      if (bram_enb) begin
        exp = ((rk / 16) % 2) * 16 + zz[rk % 16];
        n_vec++;
        if (bram_addrb !== 5'(exp)) begin
          n_err++; $display("FAIL b2b_raddr%0d got 0x%h want 0x%h", rk, bram_addrb, exp);
        end
        rk++;
      end
      if (out_valid) begin
        exp = (k / 16) * 16 + zz[k % 16];
        n_vec++;
        if (out_data !== W'(exp) || out_idx !== AW'(k % 16) || out_last !== (k % 16 == 15)) begin
          n_err++; $display("FAIL b2b_beat%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                            k, out_data, out_idx, out_last, exp, k % 16, (k % 16 == 15));
        end
        if (k > 0) begin
          n_vec++;
          if (cyc != prev + 1) begin n_err++; $display("FAIL b2b_gap beat%0d got gap %0d want 1", k, cyc - prev); end
        end
        prev = cyc; k++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (k != 48 || rk != 48 || i != 48) begin
      n_err++; $display("FAIL b2b_count got out=%0d reads=%0d in=%0d want 48 each", k, rk, i);
    end
  endtask

  task automatic test_both_full();
    int i = 0, k = 0, iss15 = -1, exp = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (i < 33); in_data = W'(50 + i);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      tick();
    end
    n_vec++;
    if (i != 32) begin n_err++; $display("FAIL full_accepted got %0d want 32", i); end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && k < 32; c++) begin
      in_valid = (i < 33); in_data = W'(50 + i);
      @(negedge clk);
      if (iss15 >= 0 && cyc == iss15) begin
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_release got in_ready=%b want 1", in_ready); end
      end
      if (bram_enb && bram_addrb === 5'h1F && iss15 < 0) begin
        iss15 = cyc + 1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_early_release got in_ready=%b want 0", in_ready); end
      end
      if (out_valid) begin
        exp = 50 + (k / 16) * 16 + zz[k % 16];
        n_vec++;
        if (out_data !== W'(exp) || out_idx !== AW'(k % 16)) begin
          n_err++; $display("FAIL full_beat%0d got d=%0d i=%0d want d=%0d i=%0d", k, out_data, out_idx, exp, k % 16);
        end
        k++;
      end
      if (in_valid && in_ready) i++;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (k != 32 || i != 33 || iss15 < 0) begin
      n_err++; $display("FAIL full_count got out=%0d in=%0d iss15=%0d want 32 33 >=0", k, i, iss15);
    end
  endtask

  task automatic test_reset_mid_scan();
    int i = 0, k = 0;
    logic done = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    for (int c = 0; c < 100 && !done; c++) begin
      in_valid = (i < 16); in_data = W'(i);
      @(negedge clk);
      if (out_valid && out_idx == AW'(7)) begin
        rst = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, out_last, out_idx, out_data} !== '0) begin
          n_err++; $display("FAIL midrst_outputs got v=%b l=%b i=%0d d=%0d want all 0", out_valid, out_last, out_idx, out_data);
        end
        n_vec++;
        if ({in_ready, bram_ena, bram_enb} !== 3'b000) begin
          n_err++; $display("FAIL midrst_ctrl got rdy/ena/enb=%b want 000", {in_ready, bram_ena, bram_enb});
        end
        done = 1'b1;
      end else if (in_valid && in_ready) begin
        i++;
      end
      if (!done) tick();
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL midrst_beat7 got no beat 7 want beat 7"); end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    i = 0;
    for (int c = 0; c < 100 && k < 16; c++) begin
      in_valid = (i < 16); in_data = W'(100 + i);
      @(negedge clk);
      if (bram_enb) begin
        n_vec++;
        if (bram_addrb[AW] !== 1'b0) begin n_err++; $display("FAIL midrst_bank got addrb=0x%h want bank 0", bram_addrb); end
      end
      if (out_valid) begin
        n_vec++;
        if (out_data !== W'(100 + zz[k]) || out_idx !== AW'(k) || out_last !== (k == 15)) begin
          n_err++; $display("FAIL midrst_beat%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                            k, out_data, out_idx, out_last, 100 + zz[k], k, (k == 15));
        end
        k++;
      end
      if (in_valid && in_ready) i++;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (k != 16) begin n_err++; $display("FAIL midrst_count got %0d want 16", k); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_both_full();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
